shift_result_buffer: RTL and testbench

- Downstream consumer of the 32-bit barrel shifter. Captures each shifter result with the operand, opcode and shift amount that produced it.
- Computes the flags zero (Z), negative (N) and carry (C, last bit shifted out).
- Queues result and flags in a small FIFO with valid/ready handshakes on both sides, decoupling the combinational shifter from the register write-back stage.

---
 rtl/shift_result_buffer.sv | 114 +++++++++++
 tb/tb_shift_result_buffer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_result_buffer.sv
// Result buffer behind the barrel shifter: tags each result with Z/N/C
// and queues it in a small FIFO between shifter and write-back.
module shift_result_buffer #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_result,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [2:0]               in_opsel,
  input  logic [4:0]               in_shamt,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_result,
  output logic [2:0]               out_flags,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [2:0]       flags;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          wr_entry;
  entry_t          head;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            push;
  logic            pop;

  logic            op_sll;
  logic            op_srl;
  logic            op_sra;
  logic            op_rol;
  logic            op_ror;
  logic [4:0]      sll_idx;
  logic [4:0]      srl_idx;
  logic            carry;
  logic            zero;
  logic            neg;

  assign in_ready  = (count != FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    op_sll = (in_opsel == 3'b000) || (in_opsel == 3'b100);
    op_srl = (in_opsel == 3'b001) || (in_opsel == 3'b101)
          || (in_opsel == 3'b111);
    op_rol = (in_opsel == 3'b010);
    op_ror = (in_opsel == 3'b011);
    op_sra = (in_opsel == 3'b110);
  end

  // 32 - shamt wraps to a 5-bit index; only used when shamt != 0
  assign sll_idx = 5'd0 - in_shamt;
  assign srl_idx = in_shamt - 5'd1;

  always_comb begin
    carry = 1'b0;
    if (in_shamt != 5'd0) begin
      unique case (1'b1)
        op_sll:         carry = in_data[sll_idx];
        op_srl, op_sra: carry = in_data[srl_idx];
        op_rol:         carry = in_result[0];
        op_ror:         carry = in_result[WIDTH-1];
        default:        carry = 1'b0;
      endcase
    end
  end

  assign zero = (in_result == '0);
  assign neg  = in_result[WIDTH-1];

  always_comb begin
    wr_entry        = '0;
    wr_entry.result = in_result;
    wr_entry.flags  = {carry, neg, zero};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= wr_entry;
  end

  assign head       = mem[rd_ptr];
  assign out_result = out_valid ? head.result : '0;
  assign out_flags  = out_valid ? head.flags  : 3'b000;

endmodule

// File: tb/tb_shift_result_buffer.sv
// Randomized bench for shift_result_buffer against a queue model,
// plus directed cases with literal expectations.
module tb_shift_result_buffer;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic [31:0] in_data;
  logic [2:0]  in_opsel;
  logic [4:0]  in_shamt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [2:0]  out_flags;
  logic [1:0]  count;

  int checks = 0;
  int errors = 0;

  logic [34:0] q[$];

  shift_result_buffer #(.DEPTH(DEPTH), .WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_data(in_data),
    .in_opsel(in_opsel), .in_shamt(in_shamt),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags),
    .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] ref_flags(
    input logic [31:0] d, input logic [31:0] r,
    input logic [2:0] op, input logic [4:0] sh);
    logic [63:0] w;
    logic c;
    c = 1'b0;
    if (sh != 0) begin
      case (op)
        3'b000, 3'b100: begin
          w = {32'b0, d} << sh;
          c = w[32];
        end
        3'b001, 3'b101, 3'b111, 3'b110: begin
          w = {d, 32'b0} >> sh;
          c = w[31];
        end
        3'b010:  c = r[0];
        default: c = r[31];
      endcase
    end
    return {c, r[31], r == 32'd0};
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] res,
                       input logic [31:0] d, input logic [2:0] op,
                       input logic [4:0] sh, input logic ordy);
    in_valid  = v;
    in_result = res;
    in_data   = d;
    in_opsel  = op;
    in_shamt  = sh;
    out_ready = ordy;
  endtask

  // Advance one clock: update the model from the sampled inputs, then
  // compare every output at the following falling edge.
  task automatic step();
    int n;
    logic [34:0] h;
    @(posedge clk);
    n = q.size();
    if (rst) begin
      q.delete();
    end else begin
      if (n != 0 && out_ready) void'(q.pop_front());
      if (in_valid && n != DEPTH)
        q.push_back({in_result,
                     ref_flags(in_data, in_result, in_opsel, in_shamt)});
    end
    @(negedge clk);
    n = q.size();
    h = (n != 0) ? q[0] : 35'd0;
    check("count", 32'(count), 32'(n));
    check("in_ready", 32'(in_ready), 32'(n != DEPTH));
    check("out_valid", 32'(out_valid), 32'(n != 0));
    check("out_result", out_result, h[34:3]);
    check("out_flags", 32'(out_flags), 32'(h[2:0]));
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b1, 32'h1234, 32'h5, 3'b000, 5'd1, 1'b1);

    check("model_sll", 32'(ref_flags(32'h80000001, 32'h2, 3'b000, 5'd1)), 32'h4);
    check("model_sra", 32'(ref_flags(32'h80000000, 32'hFFFFFFFF, 3'b110, 5'd31)), 32'h2);
    check("model_ror", 32'(ref_flags(32'h1, 32'h80000000, 3'b011, 5'd1)), 32'h6);
    check("model_op7", 32'(ref_flags(32'h4, 32'h0, 3'b111, 5'd3)), 32'h5);

    step();
    rst = 1'b0;
    check("reset_count", 32'(count), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);

    // SLL carry from bit 31
    drive(1'b1, 32'h2, 32'h80000001, 3'b000, 5'd1, 1'b0);
    step();
    check("sll_result", out_result, 32'h2);
    check("sll_flags", 32'(out_flags), 32'h4);
    check("sll_count", 32'(count), 32'd1);
    drive(1'b0, 32'h0, 32'h0, 3'b000, 5'd0, 1'b1);
    step();

    // streaming SRA, ROR, SRL shamt 0
    drive(1'b1, 32'hFFFFFFFF, 32'h80000000, 3'b110, 5'd31, 1'b1);
    step();
    check("sra_flags", 32'(out_flags), 32'h2);
    drive(1'b1, 32'h80000000, 32'h1, 3'b011, 5'd1, 1'b1);
    step();
    check("ror_result", out_result, 32'h80000000);
    check("ror_flags", 32'(out_flags), 32'h6);
    drive(1'b1, 32'h0, 32'h0, 3'b001, 5'd0, 1'b1);
    step();
    check("srl0_flags", 32'(out_flags), 32'h1);
    check("srl0_valid", 32'(out_valid), 32'd1);
    drive(1'b0, 32'h0, 32'h0, 3'b000, 5'd0, 1'b1);
    step();
    check("drained", 32'(out_valid), 32'd0);

    // full stall: a pop in the full cycle does not admit the push
    drive(1'b1, 32'hA, 32'h5, 3'b000, 5'd1, 1'b0);
    step();
    drive(1'b1, 32'hB, 32'h5, 3'b000, 5'd1, 1'b0);
    step();
    drive(1'b1, 32'hC, 32'h5, 3'b000, 5'd1, 1'b0);
    step();
    check("full_count", 32'(count), 32'd2);
    check("full_ready", 32'(in_ready), 32'd0);
    drive(1'b1, 32'hC, 32'h5, 3'b000, 5'd1, 1'b1);
    step();
    check("pop_full_count", 32'(count), 32'd1);
    check("pop_full_head", out_result, 32'hB);
    drive(1'b1, 32'hC, 32'h5, 3'b000, 5'd1, 1'b0);
    step();
    check("stall_accept", 32'(count), 32'd2);
    drive(1'b0, 32'h0, 32'h0, 3'b000, 5'd0, 1'b1);
    step();
    step();

    // push+pop at count 1 across pointer wrap
    drive(1'b1, 32'h100, 32'h1, 3'b001, 5'd2, 1'b0);
    step();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h200 + 32'(i), 32'h3, 3'b010, 5'(i), 1'b1);
      step();
      check("pp_count", 32'(count), 32'd1);
    end
    drive(1'b0, 32'h0, 32'h0, 3'b000, 5'd0, 1'b1);
    step();

    // reset mid-stream with a push pending
    drive(1'b1, 32'h11, 32'h1, 3'b000, 5'd1, 1'b0);
    step();
    step();
    rst = 1'b1;
    drive(1'b1, 32'h22, 32'h1, 3'b000, 5'd1, 1'b0);
    step();
    rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 3'b000, 5'd0, 1'b0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_result", out_result, 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);

    // opcode 111 decodes as SRL
    drive(1'b1, 32'h0, 32'h4, 3'b111, 5'd3, 1'b0);
    step();
    check("op7_flags", 32'(out_flags), 32'h5);
    drive(1'b0, 32'h0, 32'h0, 3'b000, 5'd0, 1'b1);
    step();

    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      drive($urandom_range(0, 2) != 0, $urandom, $urandom,
            3'($urandom), 5'($urandom), $urandom_range(0, 2) != 0);
      if ($urandom_range(0, 7) == 0) in_result = 32'd0;
      step();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
